// File: rtl/reg_cmd_sequencer.sv
// Expands one host command into single-cycle control strobes for a universal
// register, and keeps a shadow copy of what that register should now hold.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// EXEC  | one strobe per cycle, rem counts strobes still to follow
// DONE  | one-cycle completion pulse, then back to IDLE
module reg_cmd_sequencer #(
    parameter int W     = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [W-1:0]     cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic             cl,
    output logic             ld,
    output logic             inc,
    output logic             dec,
    output logic             sr,
    output logic             ir,
    output logic             sl,
    output logic             il,
    output logic [W-1:0]     reg_in,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     shadow
);

    localparam int RW = (CNT_W > $clog2(W)) ? CNT_W : $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_CLEAR = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_DEC   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_SHL   = 3'b110;
    localparam logic [2:0] OP_ROT   = 3'b111;

    logic [1:0]    state;
    logic [2:0]    op_q;
    logic [RW-1:0] rem;
    logic [W-1:0]  sq;
    logic [7:0]    strb_q;
    logic [7:0]    strb_nxt;
    logic [2:0]    op_sel;
    logic          idle;
    logic          accept;
    logic          zero_len;
    logic          launch;

    assign idle      = (state == S_IDLE);
    assign accept    = cmd_valid && idle;
    assign cmd_ready = idle;
    assign busy      = !idle;
    assign done      = (state == S_DONE);
    assign op_sel    = idle ? cmd_op : op_q;

    assign zero_len = (cmd_op == OP_NOP) ||
                      (((cmd_op == OP_INC) || (cmd_op == OP_DEC) || (cmd_op == OP_ROT)) &&
                       (cmd_cnt == '0));
    assign launch   = (accept && !zero_len) || ((state == S_EXEC) && (rem != '0));

    assign {cl, ld, inc, dec, sr, ir, sl, il} = strb_q;

    // Serial bits come from the live command on the accept edge, afterwards
    // from the latched word; a rotate feeds back the shadow LSB of each cycle.
    always_comb begin
        strb_nxt = '0;
        if (launch) begin
            case (op_sel)
                OP_CLEAR: strb_nxt[7] = 1'b1;
                OP_LOAD:  strb_nxt[6] = 1'b1;
                OP_INC:   strb_nxt[5] = 1'b1;
                OP_DEC:   strb_nxt[4] = 1'b1;
                OP_SHR: begin
                    strb_nxt[3] = 1'b1;
                    strb_nxt[2] = idle ? cmd_data[0] : sq[0];
                end
                OP_SHL: begin
                    strb_nxt[1] = 1'b1;
                    strb_nxt[0] = idle ? cmd_data[W-1] : sq[W-1];
                end
                OP_ROT: begin
                    strb_nxt[3] = 1'b1;
                    strb_nxt[2] = idle ? shadow[0] : shadow[1];
                end
                default: strb_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= OP_NOP;
            rem    <= '0;
            sq     <= '0;
            reg_in <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= zero_len ? S_DONE : S_EXEC;
                        op_q  <= cmd_op;
                        sq    <= (cmd_op == OP_SHL) ? (cmd_data << 1) : (cmd_data >> 1);
                        case (cmd_op)
                            OP_SHR, OP_SHL:         rem <= RW'(W - 1);
                            OP_INC, OP_DEC, OP_ROT: rem <= RW'(cmd_cnt) - RW'(1);
                            default:                rem <= '0;
                        endcase
                        if (cmd_op == OP_LOAD)
                            reg_in <= cmd_data;
                    end
                end
                S_EXEC: begin
                    sq <= (op_q == OP_SHL) ? (sq << 1) : (sq >> 1);
                    if (rem == '0)
                        state <= S_DONE;
                    else
                        rem <= rem - RW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            strb_q <= '0;
        else
            strb_q <= strb_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shadow <= '0;
        else if (cl)
            shadow <= '0;
        else if (ld)
            shadow <= reg_in;
        else if (inc)
            shadow <= shadow + W'(1);
        else if (dec)
            shadow <= shadow - W'(1);
        else if (sr)
            shadow <= {ir, shadow[W-1:1]};
        else if (sl)
            shadow <= {shadow[W-2:0], il};
    end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Bench for reg_cmd_sequencer: directed scenarios plus random back-to-back
// commands checked cycle by cycle against an arithmetic model of the register.
module tb_reg_cmd_sequencer;

    localparam int W     = 4;
    localparam int CNT_W = 4;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_CLEAR = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_DEC   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_SHL   = 3'b110;
    localparam logic [2:0] OP_ROT   = 3'b111;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [W-1:0]     cmd_data;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cl, ld, inc, dec, sr, ir, sl, il;
    logic [W-1:0]     reg_in;
    logic             busy;
    logic             done;
    logic [W-1:0]     shadow;

    logic [7:0]   strb;
    int           errors;
    int           checks;
    logic [W-1:0] m;
    logic [W-1:0] mregin;

    assign strb = {cl, ld, inc, dec, sr, ir, sl, il};

    reg_cmd_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_cnt  (cmd_cnt),
        .cl       (cl),
        .ld       (ld),
        .inc      (inc),
        .dec      (dec),
        .sr       (sr),
        .ir       (ir),
        .sl       (sl),
        .il       (il),
        .reg_in   (reg_in),
        .busy     (busy),
        .done     (done),
        .shadow   (shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one command from an IDLE negedge and follows it to the next IDLE
    // negedge, so consecutive calls give minimum accept spacing.
    task automatic run_cmd(input string tag, input logic [2:0] op,
                           input logic [W-1:0] data, input logic [CNT_W-1:0] cnt);
        int           n;
        logic [7:0]   exp;
        logic [W-1:0] nm;
        logic         b;
        case (op)
            OP_NOP:                 n = 0;
            OP_CLEAR, OP_LOAD:      n = 1;
            OP_INC, OP_DEC, OP_ROT: n = int'(cnt);
            default:                n = W;
        endcase
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_at_issue: got %b want 1", tag, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            // Noise on the command bus while busy must be ignored.
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 3'($urandom);
            cmd_data  = W'($urandom);
            cmd_cnt   = CNT_W'($urandom);
            b  = 1'b0;
            nm = m;
            exp = 8'h00;
            case (op)
                OP_CLEAR: begin exp = 8'h80; nm = '0; end
                OP_LOAD:  begin exp = 8'h40; nm = data; mregin = data; end
                OP_INC:   begin exp = 8'h20; nm = m + 4'd1; end
                OP_DEC:   begin exp = 8'h10; nm = m - 4'd1; end
                OP_SHR: begin
                    b = data[i];
                    exp = {4'b0000, 1'b1, b, 2'b00};
                    nm = (m >> 1) | {b, 3'b000};
                end
                OP_SHL: begin
                    b = data[W-1-i];
                    exp = {6'b000000, 1'b1, b};
                    nm = (m << 1) | {3'b000, b};
                end
                default: begin
                    b = m[0];
                    exp = {4'b0000, 1'b1, b, 2'b00};
                    nm = (m >> 1) | (m << (W - 1));
                end
            endcase
            checks++;
            if (strb !== exp) begin
                errors++;
                $display("FAIL %s strobe[%0d]: got %b want %b", tag, i, strb, exp);
            end
            checks++;
            if ({busy, done, cmd_ready} !== 3'b100) begin
                errors++;
                $display("FAIL %s status[%0d]: busy/done/ready got %b want 100",
                         tag, i, {busy, done, cmd_ready});
            end
            checks++;
            if (reg_in !== mregin) begin
                errors++;
                $display("FAIL %s reg_in[%0d]: got %h want %h", tag, i, reg_in, mregin);
            end
            m = nm;
            @(negedge clk);
            checks++;
            if (shadow !== m) begin
                errors++;
                $display("FAIL %s shadow[%0d]: got %h want %h", tag, i, shadow, m);
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if ({busy, done, cmd_ready, strb} !== {3'b110, 8'h00} || shadow !== m) begin
            errors++;
            $display("FAIL %s done_cycle: busy/done/ready/strb got %b_%b shadow %h want 110_00000000 shadow %h",
                     tag, {busy, done, cmd_ready}, strb, shadow, m);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, cmd_ready, strb} !== {3'b001, 8'h00} || reg_in !== mregin) begin
            errors++;
            $display("FAIL %s back_idle: busy/done/ready/strb got %b_%b reg_in %h want 001_00000000 reg_in %h",
                     tag, {busy, done, cmd_ready}, strb, reg_in, mregin);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 4'h5;
        cmd_cnt   = 4'h2;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (strb !== 8'h00 || shadow !== 4'h0 || reg_in !== 4'h0) begin
                errors++;
                $display("FAIL reset_hold: strb %b shadow %h reg_in %h want all 0", strb, shadow, reg_in);
            end
        end
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, strb, shadow, reg_in} !== {3'b100, 8'h00, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_release: ready/busy/done %b strb %b shadow %h reg_in %h want 100 0 0 0",
                     {cmd_ready, busy, done}, strb, shadow, reg_in);
        end
        m      = '0;
        mregin = '0;
    endtask

    task automatic test_load_inc();
        run_cmd("load_a", OP_LOAD, 4'hA, 4'h0);
        run_cmd("inc7", OP_INC, 4'h3, 4'd7);
        checks++;
        if (shadow !== 4'h1) begin
            errors++;
            $display("FAIL inc7_wrap: got %h want 1", shadow);
        end
    endtask

    task automatic test_dec_zero();
        run_cmd("load_3", OP_LOAD, 4'h3, 4'h0);
        run_cmd("dec0", OP_DEC, 4'hF, 4'd0);
        checks++;
        if (shadow !== 4'h3) begin
            errors++;
            $display("FAIL dec0_keep: got %h want 3", shadow);
        end
    endtask

    task automatic test_shift();
        run_cmd("clear", OP_CLEAR, 4'hF, 4'h0);
        run_cmd("shr_d", OP_SHR, 4'b1101, 4'h0);
        checks++;
        if (shadow !== 4'hD) begin
            errors++;
            $display("FAIL shr_final: got %h want d", shadow);
        end
        run_cmd("shl_6", OP_SHL, 4'b0110, 4'h0);
        checks++;
        if (shadow !== 4'h6) begin
            errors++;
            $display("FAIL shl_final: got %h want 6", shadow);
        end
    endtask

    task automatic test_rotate();
        run_cmd("load_8", OP_LOAD, 4'b1000, 4'h0);
        run_cmd("rot5", OP_ROT, 4'h0, 4'd5);
        checks++;
        if (shadow !== 4'b0100) begin
            errors++;
            $display("FAIL rot5_final: got %b want 0100", shadow);
        end
    endtask

    task automatic test_midcmd_reset();
        run_cmd("load_9", OP_LOAD, 4'h9, 4'h0);
        cmd_valid = 1'b1;
        cmd_op    = OP_INC;
        cmd_cnt   = 4'd9;
        @(negedge clk);
        cmd_op = OP_CLEAR;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (strb !== 8'h20 || shadow !== 4'hB) begin
            errors++;
            $display("FAIL midreset_pre: strb %b shadow %h want 00100000 b", strb, shadow);
        end
        cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, busy, done, strb, shadow} !== {3'b100, 8'h00, 4'h0}) begin
            errors++;
            $display("FAIL midreset_abort: ready/busy/done %b strb %b shadow %h want 100 0 0",
                     {cmd_ready, busy, done}, strb, shadow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, strb, shadow, reg_in} !== {1'b1, 8'h00, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL midreset_after: ready %b strb %b shadow %h reg_in %h want 1 0 0 0",
                     cmd_ready, strb, shadow, reg_in);
        end
        m      = '0;
        mregin = '0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++)
            run_cmd("rand", 3'($urandom), W'($urandom), CNT_W'($urandom));
        run_cmd("inc15", OP_INC, 4'h0, 4'd15);
        run_cmd("rot15", OP_ROT, 4'h0, 4'd15);
        run_cmd("nop", OP_NOP, 4'h7, 4'd3);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        m         = '0;
        mregin    = '0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        cmd_cnt   = '0;
        @(negedge clk);
        test_reset();
        test_load_inc();
        test_dec_zero();
        test_shift();
        test_rotate();
        test_midcmd_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
